// File: rtl/cmd_exec.sv
// Command executor: accepts one 2-bit command per start/ready handshake, runs it for a
// fixed per-command latency, then pulses done and tracks a saturating completion count.
module cmd_exec #(
    parameter int unsigned LAT_A  = 1,
    parameter int unsigned LAT_B  = 10,
    parameter int unsigned LAT_C  = 4,
    parameter int unsigned LAT_D  = 16,
    parameter int unsigned CNT_W  = 5,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cmd,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        done_cmd,
    output logic              aborted,
    output logic [STAT_W-1:0] cmd_count
);

    localparam int unsigned LAT_MAX = (2 ** CNT_W) - 1;

    // Every latency must fit the counter and be non-zero.
    generate
        if (LAT_A < 1 || LAT_A > LAT_MAX || LAT_B < 1 || LAT_B > LAT_MAX ||
            LAT_C < 1 || LAT_C > LAT_MAX || LAT_D < 1 || LAT_D > LAT_MAX) begin : g_bad_lat
            $fatal(1, "cmd_exec: each LAT_x must be in 1..2^CNT_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [1:0]        cmd_q, cmd_q_n;
    logic              ready_n, busy_n, done_n, aborted_n;
    logic [1:0]        done_cmd_n;
    logic [STAT_W-1:0] cmd_count_n;

    function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] c);
        case (c)
            2'b00:   lat_of = CNT_W'(LAT_A);
            2'b01:   lat_of = CNT_W'(LAT_B);
            2'b10:   lat_of = CNT_W'(LAT_C);
            default: lat_of = CNT_W'(LAT_D);
        endcase
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cmd_q     <= 2'b00;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_cmd  <= 2'b00;
            aborted   <= 1'b0;
            cmd_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cmd_q     <= cmd_q_n;
            ready     <= ready_n;
            busy      <= busy_n;
            done      <= done_n;
            done_cmd  <= done_cmd_n;
            aborted   <= aborted_n;
            cmd_count <= cmd_count_n;
        end
    end

    // Next-state and next-output logic; abort takes priority over natural completion.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cmd_q_n     = cmd_q;
        done_cmd_n  = done_cmd;
        aborted_n   = aborted;
        cmd_count_n = cmd_count;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cmd_q_n = cmd;
                    cnt_n   = lat_of(cmd);
                    state_n = S_BUSY;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_BUSY: begin
                if (abort) begin
                    state_n    = S_DONE;
                    done_cmd_n = cmd_q;
                    aborted_n  = 1'b1;
                end else if (cnt == CNT_W'(1)) begin
                    state_n    = S_DONE;
                    done_cmd_n = cmd_q;
                    aborted_n  = 1'b0;
                    if (cmd_count != {STAT_W{1'b1}}) begin
                        cmd_count_n = cmd_count + STAT_W'(1);
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        ready_n = (state_n != S_BUSY);
        busy_n  = (state_n == S_BUSY);
        done_n  = (state_n == S_DONE);
    end

endmodule
